// File: rtl/i2c_target_stretch.sv
// rtl/i2c_target_stretch.sv - I2C write-only target that stretches SCL while a received byte is unconsumed
// Optional input glitch filter enabled by defining I2C_TGT_GLITCH_FILT_EN.
module i2c_target_stretch #(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_first,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_HOLD, S_DATA_ACK, S_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_s, sda_s;
    logic                   scl_prev_q, sda_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        end
    end

`ifdef I2C_TGT_GLITCH_FILT_EN
    // Output flips only after three consecutive samples disagree with it.
    logic       scl_flt_q, sda_flt_q;
    logic [1:0] scl_cnt_q, sda_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_flt_q <= 1'b1;
            sda_flt_q <= 1'b1;
            scl_cnt_q <= 2'd0;
            sda_cnt_q <= 2'd0;
        end else begin
            if (scl_sync_q[SYNC_STAGES-1] == scl_flt_q) begin
                scl_cnt_q <= 2'd0;
            end else if (scl_cnt_q == 2'd2) begin
                scl_flt_q <= ~scl_flt_q;
                scl_cnt_q <= 2'd0;
            end else begin
                scl_cnt_q <= scl_cnt_q + 2'd1;
            end
            if (sda_sync_q[SYNC_STAGES-1] == sda_flt_q) begin
                sda_cnt_q <= 2'd0;
            end else if (sda_cnt_q == 2'd2) begin
                sda_flt_q <= ~sda_flt_q;
                sda_cnt_q <= 2'd0;
            end else begin
                sda_cnt_q <= sda_cnt_q + 2'd1;
            end
        end
    end

    assign scl_s = scl_flt_q;
    assign sda_s = sda_flt_q;
`else
    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];
`endif

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       sda_oe_q, sda_oe_d;
    logic       scl_oe_q, scl_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_first_q, rx_first_d;
    logic       first_q, first_d;
    logic       nine_q, nine_d;
    logic       stretch_now;

    logic       scl_rise, scl_fall, start_det, stop_det, handshake, last_bit;
    logic [7:0] next_byte;

    // Our own SDA/SCL drive must never be mistaken for a bus condition.
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = ~(sda_oe_q | scl_oe_q) & scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = ~(sda_oe_q | scl_oe_q) & scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign handshake = rx_valid_q & rx_ready;
    assign next_byte = {shift_q, sda_s};
    assign last_bit  = scl_rise & (bit_cnt_q == 3'd7);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        sda_oe_d    = sda_oe_q;
        scl_oe_d    = scl_oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        rx_first_d  = rx_first_q;
        first_d     = first_q;
        nine_d      = nine_q;
        stretch_now = 1'b0;

        if (handshake) begin
            rx_valid_d = 1'b0;
            rx_first_d = 1'b0;
        end
        if (scl_rise) begin
            shift_d   = next_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        if (start_det) begin
            state_d   = S_ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            scl_oe_d  = 1'b0;
            nine_d    = 1'b0;
        end else if (stop_det) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            scl_oe_d = 1'b0;
            nine_d   = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (last_bit) begin
                        state_d = (next_byte[7:1] == ADDR && !next_byte[0]) ? S_ADDR_ACK : S_IGNORE;
                    end
                end
                S_ADDR_ACK, S_DATA_ACK: begin
                    if (scl_rise && sda_oe_q) begin
                        nine_d = 1'b1;
                    end
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else if (nine_q) begin
                            sda_oe_d  = 1'b0;
                            nine_d    = 1'b0;
                            bit_cnt_d = 3'd0;
                            state_d   = S_DATA;
                            if (state_q == S_ADDR_ACK) begin
                                first_d = 1'b1;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (last_bit) begin
                        rx_data_d  = next_byte;
                        rx_valid_d = 1'b1;
                        rx_first_d = first_q;
                        first_d    = 1'b0;
                        state_d    = S_DATA_HOLD;
                    end
                end
                S_DATA_HOLD: begin
                    // While stretching, ACK goes out one clk before SCL is let go.
                    if (scl_oe_q) begin
                        if (handshake) begin
                            sda_oe_d = 1'b1;
                        end else if (!rx_valid_q) begin
                            scl_oe_d = 1'b0;
                            state_d  = S_DATA_ACK;
                        end
                    end else if (scl_fall) begin
                        if (rx_valid_q) begin
                            scl_oe_d    = 1'b1;
                            stretch_now = 1'b1;
                            if (handshake) begin
                                sda_oe_d = 1'b1;
                            end
                        end else begin
                            sda_oe_d = 1'b1;
                            state_d  = S_DATA_ACK;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            first_q    <= 1'b0;
            nine_q     <= 1'b0;
        end else begin
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sda_oe_q   <= sda_oe_d;
            scl_oe_q   <= scl_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_first_q <= rx_first_d;
            first_q    <= first_d;
            nine_q     <= nine_d;
        end
    end

    assign scl_oe   = scl_oe_q | stretch_now;
    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_first = rx_first_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_i2c_target_stretch.sv
// tb/tb_i2c_target_stretch.sv - bench for i2c_target_stretch acting as an open-drain I2C controller
module tb_i2c_target_stretch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_c = 1'b1;
    logic       sda_c = 1'b1;
    logic       rx_ready = 1'b0;
    logic       scl_line, sda_line;
    logic       scl_oe, sda_oe, rx_valid, rx_first, busy;
    logic [7:0] rx_data;

    assign scl_line = scl_c & ~scl_oe;
    assign sda_line = sda_c & ~sda_oe;

    i2c_target_stretch #(.ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl_line),
        .sda_in   (sda_line),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_first (rx_first),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       first;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   nrx = 0;
    logic scl_seen = 1'b0;
    logic sda_seen = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic ack;
    logic ack2;

    function automatic void chk(input logic ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic scl_up();
        int n;
        scl_c = 1'b1;
        n = 0;
        while (!scl_line && n < 2000) begin
            tick(1);
            n++;
        end
        chk(scl_line, "scl_release_timeout", {31'd0, scl_line}, 32'd1);
    endtask

    task automatic i2c_start();
        sda_c = 1'b1;
        tick(5);
        scl_up();
        tick(10);
        sda_c = 1'b0;
        tick(10);
        scl_c = 1'b0;
        tick(5);
    endtask

    task automatic i2c_stop();
        sda_c = 1'b0;
        tick(5);
        scl_up();
        tick(10);
        sda_c = 1'b1;
        tick(10);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) begin
            sda_c = b[i];
            tick(5);
            scl_up();
            tick(10);
            scl_c = 1'b0;
            tick(5);
        end
        sda_c = 1'b1;
        tick(5);
        scl_up();
        tick(5);
        a = sda_line;
        tick(5);
        scl_c = 1'b0;
        tick(5);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!rx_valid && n < 3000) begin
            tick(1);
            n++;
        end
        chk(rx_valid, "wait_valid_timeout", {31'd0, rx_valid}, 32'd1);
    endtask

    task automatic consume(input int dly);
        if (dly == 0) begin
            rx_ready = 1'b1;
            wait_valid();
            tick(1);
            chk(!rx_valid, "valid_one_clk", {31'd0, rx_valid}, 32'd0);
            rx_ready = 1'b0;
        end else begin
            rx_ready = 1'b0;
            wait_valid();
            tick(dly);
            chk(scl_oe, "stretch_active", {31'd0, scl_oe}, 32'd1);
            chk(rx_valid, "pending_held", {31'd0, rx_valid}, 32'd1);
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
            chk(!rx_valid, "hs_valid_clr", {31'd0, rx_valid}, 32'd0);
            chk(sda_oe, "hs_ack_setup", {31'd0, sda_oe}, 32'd1);
            chk(scl_oe, "hs_scl_still_low", {31'd0, scl_oe}, 32'd1);
            tick(1);
            chk(!scl_oe, "hs_scl_release", {31'd0, scl_oe}, 32'd0);
            chk(sda_oe, "hs_ack_kept", {31'd0, sda_oe}, 32'd1);
        end
    endtask

    // Expected-byte scoreboard: any presented byte must match the head of exp_q.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                prev_ready = 1'b0;
            end else begin
                if (scl_oe) begin
                    scl_seen = 1'b1;
                    chk(rx_valid || sda_oe, "stretch_reason", {30'd0, rx_valid, sda_oe}, 32'd2);
                end
                if (sda_oe) sda_seen = 1'b1;
                if (prev_valid && !prev_ready)
                    chk(rx_valid, "valid_held", {31'd0, rx_valid}, 32'd1);
                if (rx_valid) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_byte", {23'd0, rx_first, rx_data}, 32'd0);
                    end else begin
                        chk({rx_first, rx_data} == {exp_q[0].first, exp_q[0].data}, "rx_byte",
                            {23'd0, rx_first, rx_data}, {23'd0, exp_q[0].first, exp_q[0].data});
                        if (rx_ready) begin
                            void'(exp_q.pop_front());
                            nrx++;
                        end
                    end
                end
                prev_valid = rx_valid;
                prev_ready = rx_ready;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout at %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        tick(3);
        chk(scl_oe == 1'b0, "rst_scl_oe", {31'd0, scl_oe}, 32'd0);
        chk(sda_oe == 1'b0, "rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk(rx_valid == 1'b0, "rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk(rx_first == 1'b0, "rst_rx_first", {31'd0, rx_first}, 32'd0);
        chk(busy == 1'b0, "rst_busy", {31'd0, busy}, 32'd0);
        chk(rx_data == 8'h00, "rst_rx_data", {24'd0, rx_data}, 32'd0);
        rst_n = 1'b1;
        tick(5);

        // Basic write, consumer always ready
        scl_seen = 1'b0;
        i2c_start();
        chk(busy, "t1_busy_start", {31'd0, busy}, 32'd1);
        fork
            begin
                write_byte(8'h84, ack);
                chk(ack == 1'b0, "t1_addr_ack", {31'd0, ack}, 32'd0);
                exp_q.push_back('{first: 1'b1, data: 8'hA5});
                write_byte(8'hA5, ack);
                chk(ack == 1'b0, "t1_data_ack", {31'd0, ack}, 32'd0);
            end
            consume(0);
        join
        i2c_stop();
        chk(busy == 1'b0, "t1_busy_idle", {31'd0, busy}, 32'd0);
        chk(scl_seen == 1'b0, "t1_no_stretch", {31'd0, scl_seen}, 32'd0);

        // Slow consumer forces a stretch
        i2c_start();
        fork
            begin
                write_byte(8'h84, ack);
                chk(ack == 1'b0, "t2_addr_ack", {31'd0, ack}, 32'd0);
                exp_q.push_back('{first: 1'b1, data: 8'hA5});
                write_byte(8'hA5, ack);
                chk(ack == 1'b0, "t2_data_ack", {31'd0, ack}, 32'd0);
            end
            consume(200);
        join
        i2c_stop();
        chk(busy == 1'b0, "t2_busy_idle", {31'd0, busy}, 32'd0);

        // Wrong address: no ACK, nothing captured
        sda_seen = 1'b0;
        i2c_start();
        write_byte(8'h86, ack);
        chk(ack == 1'b1, "t3_addr_nack", {31'd0, ack}, 32'd1);
        write_byte(8'h55, ack);
        chk(ack == 1'b1, "t3_data_nack", {31'd0, ack}, 32'd1);
        i2c_stop();
        chk(sda_seen == 1'b0, "t3_no_sda", {31'd0, sda_seen}, 32'd0);
        chk(nrx == 2, "t3_nrx", nrx, 32'd2);

        // Read request is NACKed, then repeated START with a write
        i2c_start();
        write_byte(8'h85, ack);
        chk(ack == 1'b1, "t4_read_nack", {31'd0, ack}, 32'd1);
        chk(busy, "t4_busy_ignore", {31'd0, busy}, 32'd1);
        i2c_start();
        fork
            begin
                write_byte(8'h84, ack2);
                chk(ack2 == 1'b0, "t4_addr_ack", {31'd0, ack2}, 32'd0);
                exp_q.push_back('{first: 1'b1, data: 8'h3C});
                write_byte(8'h3C, ack2);
                chk(ack2 == 1'b0, "t4_data_ack", {31'd0, ack2}, 32'd0);
            end
            consume(0);
        join
        i2c_stop();

        // Two bytes: fast path for first, stretched path for second
        scl_seen = 1'b0;
        i2c_start();
        fork
            begin
                write_byte(8'h84, ack);
                chk(ack == 1'b0, "t5_addr_ack", {31'd0, ack}, 32'd0);
                exp_q.push_back('{first: 1'b1, data: 8'h11});
                write_byte(8'h11, ack);
                chk(ack == 1'b0, "t5_ack_11", {31'd0, ack}, 32'd0);
                exp_q.push_back('{first: 1'b0, data: 8'h22});
                write_byte(8'h22, ack);
                chk(ack == 1'b0, "t5_ack_22", {31'd0, ack}, 32'd0);
            end
            begin
                consume(0);
                chk(scl_seen == 1'b0, "t5_no_stretch_11", {31'd0, scl_seen}, 32'd0);
                consume(150);
            end
        join
        i2c_stop();
        chk(nrx == 5, "t5_nrx", nrx, 32'd5);

        // Reset while stretching
        i2c_start();
        fork
            begin
                write_byte(8'h84, ack);
                exp_q.push_back('{first: 1'b1, data: 8'h77});
                write_byte(8'h77, ack);
            end
            begin
                rx_ready = 1'b0;
                wait_valid();
                tick(50);
                chk(scl_oe, "t6_stretching", {31'd0, scl_oe}, 32'd1);
                rst_n = 1'b0;
                #1;
                chk(scl_oe == 1'b0, "t6_rst_scl", {31'd0, scl_oe}, 32'd0);
                chk(sda_oe == 1'b0, "t6_rst_sda", {31'd0, sda_oe}, 32'd0);
                chk(rx_valid == 1'b0, "t6_rst_valid", {31'd0, rx_valid}, 32'd0);
                chk(busy == 1'b0, "t6_rst_busy", {31'd0, busy}, 32'd0);
                exp_q.delete();
                tick(2);
                rst_n = 1'b1;
            end
        join
        i2c_stop();
        tick(5);
        i2c_start();
        fork
            begin
                write_byte(8'h84, ack);
                chk(ack == 1'b0, "t6_addr_ack", {31'd0, ack}, 32'd0);
                exp_q.push_back('{first: 1'b1, data: 8'h5A});
                write_byte(8'h5A, ack);
                chk(ack == 1'b0, "t6_data_ack", {31'd0, ack}, 32'd0);
            end
            consume(0);
        join
        i2c_stop();
        chk(busy == 1'b0, "t6_busy_idle", {31'd0, busy}, 32'd0);

        tick(5);
        chk(exp_q.size() == 0, "exp_drained", exp_q.size(), 32'd0);
        chk(nrx == 6, "bytes_received", nrx, 32'd6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
